// File: rtl/rat_reduce.sv
// rtl/rat_reduce.sv - sequential reducer of a signed rational to lowest terms
//
// Binary (Stein) GCD of |num| and |den|, then two parallel restoring
// dividers produce |num|/g and |den|/g. Sign is reapplied to the numerator,
// so the denominator is always non-negative.
//
// Optional feature macro: RAT_REDUCE_ZERO_CHECK_EN
//   defined   : in_den==0 gives 0/0 with out_err=1
//   undefined : out_err tied 0, x/0 reduces to +-1/0
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake, in_num/in_den signed operands
//   out_valid/out_ready   output handshake, held until accepted
//   out_num/out_den       reduced result, out_den positive
//   out_err               zero-denominator flag (feature macro only)
module rat_reduce #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_num,
    input  logic [WIDTH-1:0] in_den,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_num,
    output logic [WIDTH-1:0] out_den,
    output logic             out_err
);
    localparam int KW = $clog2(WIDTH);
    localparam logic [KW-1:0] LAST = KW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, STRIP, GCD, DIV, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a, b;      // GCD working pair
    logic [WIDTH-1:0] an, ad;    // |num|, |den| kept for the divide step
    logic [WIDTH-1:0] g;         // final gcd, divisor for both dividers
    logic [WIDTH-1:0] qn, qd;    // dividend shifts out / quotient shifts in
    logic [WIDTH-1:0] rn, rd;    // partial remainders (always < g)
    logic [KW-1:0]    k;         // common power of two stripped
    logic [KW-1:0]    cnt;       // divide step counter
    logic             sgn;

    // Magnitudes; the most-negative value maps to 2^(W-1) as unsigned.
    logic [WIDTH-1:0] abs_num, abs_den;
    assign abs_num = in_num[WIDTH-1] ? (WIDTH'(0) - in_num) : in_num;
    assign abs_den = in_den[WIDTH-1] ? (WIDTH'(0) - in_den) : in_den;

    // One restoring-division step for each divider. The shifted remainder
    // can reach 2g-1, hence the extra bit.
    logic [WIDTH:0]   sn, sd, gx;
    logic             ge_n, ge_d;
    logic [WIDTH-1:0] rn_nxt, rd_nxt, qn_nxt, qd_nxt;
    logic [WIDTH:0]   sn_sub, sd_sub;
    assign gx     = {1'b0, g};
    assign sn     = {rn, qn[WIDTH-1]};
    assign sd     = {rd, qd[WIDTH-1]};
    assign ge_n   = (sn >= gx);
    assign ge_d   = (sd >= gx);
    assign sn_sub = sn - gx;
    assign sd_sub = sd - gx;
    assign rn_nxt = ge_n ? sn_sub[WIDTH-1:0] : sn[WIDTH-1:0];
    assign rd_nxt = ge_d ? sd_sub[WIDTH-1:0] : sd[WIDTH-1:0];
    assign qn_nxt = {qn[WIDTH-2:0], ge_n};
    assign qd_nxt = {qd[WIDTH-2:0], ge_d};

`ifdef RAT_REDUCE_ZERO_CHECK_EN
    logic err_q;
    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_num   <= '0;
            out_den   <= '0;
            a         <= '0;
            b         <= '0;
            an        <= '0;
            ad        <= '0;
            g         <= '0;
            qn        <= '0;
            qd        <= '0;
            rn        <= '0;
            rd        <= '0;
            k         <= '0;
            cnt       <= '0;
            sgn       <= 1'b0;
`ifdef RAT_REDUCE_ZERO_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        a        <= abs_num;
                        b        <= abs_den;
                        an       <= abs_num;
                        ad       <= abs_den;
                        sgn      <= in_num[WIDTH-1] ^ in_den[WIDTH-1];
                        k        <= '0;
                        if (in_num == '0) begin
                            // Zero numerator wins over a zero denominator.
                            out_num   <= '0;
                            out_den   <= WIDTH'(1);
                            out_valid <= 1'b1;
`ifdef RAT_REDUCE_ZERO_CHECK_EN
                            err_q     <= 1'b0;
`endif
                            state     <= DONE;
`ifdef RAT_REDUCE_ZERO_CHECK_EN
                        end else if (in_den == '0) begin
                            out_num   <= '0;
                            out_den   <= '0;
                            out_valid <= 1'b1;
                            err_q     <= 1'b1;
                            state     <= DONE;
`endif
                        end else begin
                            state <= STRIP;
                        end
                    end
                end
                STRIP: begin
                    if (!a[0] && !b[0]) begin
                        a <= a >> 1;
                        b <= b >> 1;
                        k <= k + 1'b1;
                    end else begin
                        state <= GCD;
                    end
                end
                GCD: begin
                    // Entering DIV also loads both dividers.
                    if (a == '0 || b == '0) begin
                        g     <= (a == '0) ? (b << k) : (a << k);
                        qn    <= an;
                        qd    <= ad;
                        rn    <= '0;
                        rd    <= '0;
                        cnt   <= '0;
                        state <= DIV;
                    end else if (!a[0]) begin
                        a <= a >> 1;
                    end else if (!b[0]) begin
                        b <= b >> 1;
                    end else if (a >= b) begin
                        a <= a - b;
                    end else begin
                        b <= b - a;
                    end
                end
                DIV: begin
                    qn  <= qn_nxt;
                    qd  <= qd_nxt;
                    rn  <= rn_nxt;
                    rd  <= rd_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        out_num   <= sgn ? (WIDTH'(0) - qn_nxt) : qn_nxt;
                        out_den   <= qd_nxt;
                        out_valid <= 1'b1;
`ifdef RAT_REDUCE_ZERO_CHECK_EN
                        err_q     <= 1'b0;
`endif
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rat_reduce.sv
// tb/tb_rat_reduce.sv - randomized and directed self-checking bench for rat_reduce
module tb_rat_reduce;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_num;
    logic [31:0] in_den;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_num;
    logic [31:0] out_den;
    logic        out_err;

    int checks = 0;
    int errors = 0;

    rat_reduce #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_num    (in_num),
        .in_den    (in_den),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_num   (out_num),
        .out_den   (out_den),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: Euclid on 64-bit magnitudes, then exact division.
    function automatic void model(input logic [31:0] n, input logic [31:0] d,
                                  output logic [31:0] en, output logic [31:0] ed,
                                  output logic ee);
        longint sn, sd, mn, md, x, y, t, q1, q2;
        sn = longint'($signed(n));
        sd = longint'($signed(d));
        mn = (sn < 0) ? -sn : sn;
        md = (sd < 0) ? -sd : sd;
        ee = 1'b0;
        if (n == 0) begin
            en = 32'd0; ed = 32'd1;
            return;
        end
`ifdef RAT_REDUCE_ZERO_CHECK_EN
        if (d == 0) begin
            en = 32'd0; ed = 32'd0; ee = 1'b1;
            return;
        end
`endif
        x = mn; y = md;
        while (y != 0) begin
            t = x % y; x = y; y = t;
        end
        q1 = mn / x;
        q2 = md / x;
        en = (n[31] ^ d[31]) ? 32'(-q1) : 32'(q1);
        ed = 32'(q2);
    endfunction

    task automatic xfer(input logic [31:0] n, input logic [31:0] d, input int hold);
        logic [31:0] en, ed;
        logic        ee;
        int          lat;
        logic [31:0] hn, hd;
        model(n, d, en, ed, ee);
        chk("idle_ready", {31'd0, in_ready}, 32'd1);
        in_num    = n;
        in_den    = d;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ready_drop", {31'd0, in_ready}, 32'd0);
        lat = 1;
        while (!out_valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
        chk("out_num", out_num, en);
        chk("out_den", out_den, ed);
        chk("out_err", {31'd0, out_err}, {31'd0, ee});
        if (n == 0 || ee) chk("early_latency", 32'(lat), 32'd1);
        hn = out_num;
        hd = out_den;
        for (int i = 0; i < hold; i++) begin
            if (i % 3 == 0) begin
                in_valid = 1'b1;
                in_num   = $urandom;
                in_den   = $urandom | 32'd1;
            end
            @(negedge clk);
            in_valid = 1'b0;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_num", out_num, hn);
            chk("hold_den", out_den, hd);
            chk("hold_busy", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid", {31'd0, out_valid}, 32'd0);
        chk("post_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] n, d, m;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_num    = '0;
        in_den    = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_num", out_num, 32'd0);
        chk("rst_out_den", out_den, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        xfer(32'd6, 32'd8, 0);
        xfer(32'd1, 32'd1, 0);
        xfer(-32'sd10, 32'd4, 0);
        xfer(32'd7, -32'sd21, 0);
        xfer(-32'sd9, -32'sd12, 0);
        xfer(32'd0, 32'd5, 0);
        xfer(32'd0, -32'sd7, 0);
        xfer(32'd0, 32'd0, 0);
        xfer(32'd12, 32'd0, 0);
        xfer(-32'sd12, 32'd0, 0);
        xfer(32'h8000_0000, 32'd2, 0);
        xfer(32'h8000_0000, 32'hFFFF_FFFF, 0);
        xfer(32'h7FFF_FFFF, 32'h8000_0000, 0);
        xfer(32'h4000_0000, 32'h0010_0000, 10);

        for (int i = 0; i < 24; i++) begin
            m = $urandom_range(1, 4096);
            n = (32'($urandom_range(0, 2000)) - 32'd1000) * m;
            d = (32'($urandom_range(0, 2000)) - 32'd1000) * m;
            if (d == 0) d = m;
            xfer(n, d, (i % 6 == 0) ? 3 : 0);
        end
        for (int i = 0; i < 8; i++) begin
            n = $urandom;
            d = $urandom;
            if (d == 0) d = 32'd3;
            xfer(n, d, 0);
        end

        // Reset while the GCD loop is in flight.
        in_num   = 32'h7FFF_FFFF;
        in_den   = 32'h7FFF_FFFE;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_before_reset", {31'd0, in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_in_ready", {31'd0, in_ready}, 32'd1);
        chk("async_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_out_num", out_num, 32'd0);
        chk("async_out_den", out_den, 32'd0);
        chk("async_out_err", {31'd0, out_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("reset_no_output", {31'd0, out_valid}, 32'd0);
        xfer(32'd4, 32'd2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
